cfxp_mac: RTL and testbench

Pipelined complex fixed-point arithmetic unit with a runtime-selectable operation: add, subtract, multiply, conjugate-multiply, and multiply-accumulate. Uses valid/ready flow control, round-half-up rounding and optional saturation. It is the next-generation complex processing element for the filter datapath. Several coefficient/sample products can be accumulated in one unit instead of chaining separate adders and multipliers.

---
 rtl/cfxp_mac_pkg.sv | 31 +++
 rtl/cfxp_rmul.sv | 18 +
 rtl/cfxp_mac.sv | 112 +++++++++++
 tb/tb_cfxp_mac.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/cfxp_mac_pkg.sv
// rtl/cfxp_mac_pkg.sv - shared operation codes and saturation helper for the complex fixed-point unit
package FPU_p;

    typedef enum logic [2:0] {
        CADD  = 3'd0,
        CSUB  = 3'd1,
        CMULT = 3'd2,
        CMULC = 3'd3,
        CMAC  = 3'd4
    } cop_t;

    typedef struct packed {
        logic [63:0] word;
        logic        ovf;
    } sat_t;

    // Range is [-2^n_tot, 2^n_tot-1]; callers keep the low n_tot+1 bits of word.
    function automatic sat_t sat_fxp(input logic signed [63:0] value, input int n_tot, input logic sat);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        sat_t r;
        hi     = (64'sd1 <<< n_tot) - 64'sd1;
        lo     = -(64'sd1 <<< n_tot);
        r.ovf  = (value > hi) || (value < lo);
        r.word = value;
        if (sat && value > hi) r.word = hi;
        if (sat && value < lo) r.word = lo;
        return r;
    endfunction

endpackage

// File: rtl/cfxp_rmul.sv
// rtl/cfxp_rmul.sv - signed multiply with round-half-up and fractional shift
module cfxp_rmul #(
    parameter int W      = 32,
    parameter int n_mant = 23,
    parameter int PW     = 2 * W - n_mant
) (
    input  logic signed [W-1:0]  a,
    input  logic signed [W-1:0]  b,
    output logic signed [PW-1:0] p
);
    localparam logic signed [2*W-1:0] HALF = {{(2*W-1){1'b0}}, 1'b1} << (n_mant - 1);

    logic signed [2*W-1:0] full;

    assign full = a * b;
    assign p    = PW'((full + HALF) >>> n_mant);

endmodule

// File: rtl/cfxp_mac.sv
// rtl/cfxp_mac.sv - three-stage complex add/sub/mult/conj-mult/MAC with global-stall flow control
module cfxp_mac
    import FPU_p::*;
#(
    parameter int   n_int  = 8,
    parameter int   n_mant = 23,
    parameter logic sat    = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  cop_t                      op,
    input  logic                      acc_clr,
    input  logic signed [n_int+n_mant:0] AR,
    input  logic signed [n_int+n_mant:0] AI,
    input  logic signed [n_int+n_mant:0] BR,
    input  logic signed [n_int+n_mant:0] BI,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic signed [n_int+n_mant:0] resultR,
    output logic signed [n_int+n_mant:0] resultI,
    output logic                      ovf
);
    localparam int n_tot = n_int + n_mant;
    localparam int W     = n_tot + 1;
    localparam int PW    = 2 * W - n_mant;
    // Wide enough for a full rounded product sum so product overflow is still detected.
    localparam int SW    = PW + 2;

    logic adv;
    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    logic            v1, clr1;
    cop_t            op1;
    logic signed [W-1:0] ar1, ai1, br1, bi1;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v1 <= 1'b0; clr1 <= 1'b0; op1 <= CADD;
            ar1 <= '0; ai1 <= '0; br1 <= '0; bi1 <= '0;
        end else if (adv) begin
            v1 <= in_valid; clr1 <= acc_clr; op1 <= op;
            ar1 <= AR; ai1 <= AI; br1 <= BR; bi1 <= BI;
        end
    end

    logic signed [PW-1:0] p_rr, p_ii, p_ir, p_ri;
    cfxp_rmul #(.W(W), .n_mant(n_mant)) u_rr (.a(ar1), .b(br1), .p(p_rr));
    cfxp_rmul #(.W(W), .n_mant(n_mant)) u_ii (.a(ai1), .b(bi1), .p(p_ii));
    cfxp_rmul #(.W(W), .n_mant(n_mant)) u_ir (.a(ai1), .b(br1), .p(p_ir));
    cfxp_rmul #(.W(W), .n_mant(n_mant)) u_ri (.a(ar1), .b(bi1), .p(p_ri));

    logic is_mul1;
    assign is_mul1 = (op1 == CMULT) || (op1 == CMULC) || (op1 == CMAC);

    logic             v2, clr2;
    cop_t             op2;
    logic signed [SW-1:0] x0, x1, x2, x3;

    // Add/sub reuse the product slots: x0/x1 carry the real parts, x2/x3 the imaginary parts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            v2 <= 1'b0; clr2 <= 1'b0; op2 <= CADD;
            x0 <= '0; x1 <= '0; x2 <= '0; x3 <= '0;
        end else if (adv) begin
            v2 <= v1; clr2 <= clr1; op2 <= op1;
            x0 <= is_mul1 ? SW'(p_rr) : SW'(ar1);
            x1 <= is_mul1 ? SW'(p_ii) : SW'(br1);
            x2 <= is_mul1 ? SW'(p_ir) : SW'(ai1);
            x3 <= is_mul1 ? SW'(p_ri) : SW'(bi1);
        end
    end

    logic signed [W-1:0]  acc_r, acc_i, nr, ni;
    logic signed [SW-1:0] sum_r, sum_i, base_r, base_i;
    logic                 sub_r, sub_i;
    sat_t                 sr, si;

    always_comb begin
        sub_r  = (op2 == CSUB) || (op2 == CMULT) || (op2 == CMAC);
        sub_i  = (op2 == CSUB) || (op2 == CMULC);
        base_r = (op2 == CMAC && !clr2) ? SW'(acc_r) : '0;
        base_i = (op2 == CMAC && !clr2) ? SW'(acc_i) : '0;
        sum_r  = base_r + (sub_r ? (x0 - x1) : (x0 + x1));
        sum_i  = base_i + (sub_i ? (x2 - x3) : (x2 + x3));
        sr     = sat_fxp(64'(sum_r), n_tot, sat);
        si     = sat_fxp(64'(sum_i), n_tot, sat);
        nr     = W'(sr.word);
        ni     = W'(si.word);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0; resultR <= '0; resultI <= '0; ovf <= 1'b0;
            acc_r <= '0; acc_i <= '0;
        end else if (adv) begin
            out_valid <= v2;
            if (v2) begin
                resultR <= nr;
                resultI <= ni;
                ovf     <= sr.ovf | si.ovf;
                if (op2 == CMAC) begin
                    acc_r <= nr;
                    acc_i <= ni;
                end
            end
        end
    end

endmodule

// File: tb/tb_cfxp_mac.sv
// tb/tb_cfxp_mac.sv - table and scoreboard bench for cfxp_mac (saturating and wrapping instances)
module tb_cfxp_mac;
    import FPU_p::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        in_valid = 1'b0, out_ready = 1'b1, acc_clr = 1'b0;
    cop_t        op = CADD;
    logic signed [31:0] ar = '0, ai = '0, br = '0, bi = '0;
    logic        in_ready, in_ready_w, out_valid, out_valid_w, ovf, ovfw;
    logic signed [31:0] rr, ri, rrw, riw;

    cfxp_mac #(.sat(1'b1)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op), .acc_clr(acc_clr),
        .AR(ar), .AI(ai), .BR(br), .BI(bi), .out_valid(out_valid), .out_ready(out_ready),
        .resultR(rr), .resultI(ri), .ovf(ovf));

    cfxp_mac #(.sat(1'b0)) dut_w (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready_w), .op(op), .acc_clr(acc_clr),
        .AR(ar), .AI(ai), .BR(br), .BI(bi), .out_valid(out_valid_w), .out_ready(out_ready),
        .resultR(rrw), .resultI(riw), .ovf(ovfw));

    typedef struct {
        logic [31:0] r, i, rw, iw;
        logic        o;
    } exp_t;

    typedef struct {
        cop_t        op;
        logic        clr;
        logic [31:0] ar, ai, br, bi;
        exp_t        e;
    } vec_t;

    exp_t sb[$];
    vec_t v[15];
    int   total = 0;
    int   bad   = 0;

    function automatic exp_t ex(input logic [31:0] r, input logic [31:0] i, input logic o,
                                input logic [31:0] rw, input logic [31:0] iw);
        exp_t e;
        e.r = r; e.i = i; e.o = o; e.rw = rw; e.iw = iw;
        return e;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, expv);
        end
    endtask

    task automatic fail_now(input string name);
        total++;
        bad++;
        $display("FAIL %s: got timeout want event", name);
    endtask

    task automatic send(input cop_t o, input logic c, input logic [31:0] a_r, input logic [31:0] a_i,
                        input logic [31:0] b_r, input logic [31:0] b_i, input exp_t e);
        bit acc;
        int n;
        acc = 1'b0;
        n   = 0;
        op = o; acc_clr = c; ar = a_r; ai = a_i; br = b_r; bi = b_i; in_valid = 1'b1;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            n++;
        end while (!acc && n < 50);
        if (acc) sb.push_back(e);
        else fail_now("send_accept");
        #1 in_valid = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 60) begin
            @(posedge clk);
            n++;
        end
        if (sb.size() != 0) fail_now("drain");
        @(posedge clk);
        #1;
    endtask

    task automatic wait_out();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!out_valid && n < 20);
        if (!out_valid) fail_now("wait_out_valid");
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_out: got %h want none", rr);
            end else begin
                chk("resultR", rr, sb[0].r);
                chk("resultI", ri, sb[0].i);
                chk("ovf", {31'b0, ovf}, {31'b0, sb[0].o});
                chk("wrap_valid", {31'b0, out_valid_w}, 32'd1);
                chk("wrap_resultR", rrw, sb[0].rw);
                chk("wrap_resultI", riw, sb[0].iw);
                chk("wrap_ovf", {31'b0, ovfw}, {31'b0, sb[0].o});
                if (out_ready) void'(sb.pop_front());
            end
        end
    end

    initial begin
        v[0]  = '{CMULT, 1'b0, 32'h00C00000, 32'h01000000, 32'h00400000, 32'hFF800000,
                  ex(32'h01600000, 32'hFFC00000, 1'b0, 32'h01600000, 32'hFFC00000)};
        v[1]  = '{CMAC, 1'b1, 32'h00800000, 32'h00800000, 32'h00800000, 32'h0,
                  ex(32'h00800000, 32'h00800000, 1'b0, 32'h00800000, 32'h00800000)};
        v[2]  = '{CMAC, 1'b0, 32'h0, 32'h00800000, 32'h0, 32'h00800000,
                  ex(32'h0, 32'h00800000, 1'b0, 32'h0, 32'h00800000)};
        v[3]  = '{CMAC, 1'b1, 32'h01000000, 32'h0, 32'h00800000, 32'h0,
                  ex(32'h01000000, 32'h0, 1'b0, 32'h01000000, 32'h0)};
        v[4]  = '{CADD, 1'b0, 32'h64000000, 32'h0, 32'h32000000, 32'h0,
                  ex(32'h7FFFFFFF, 32'h0, 1'b1, 32'h96000000, 32'h0)};
        v[5]  = '{CMULT, 1'b0, 32'h1, 32'h0, 32'h00400000, 32'h0,
                  ex(32'h1, 32'h0, 1'b0, 32'h1, 32'h0)};
        v[6]  = '{CMULT, 1'b0, 32'hFFFFFFFF, 32'h0, 32'h00400000, 32'h0,
                  ex(32'h0, 32'h0, 1'b0, 32'h0, 32'h0)};
        v[7]  = '{CMULC, 1'b0, 32'h00800000, 32'h00800000, 32'h00800000, 32'h00800000,
                  ex(32'h01000000, 32'h0, 1'b0, 32'h01000000, 32'h0)};
        v[8]  = '{CSUB, 1'b0, 32'h01800000, 32'h00800000, 32'h00800000, 32'h01000000,
                  ex(32'h01000000, 32'hFF800000, 1'b0, 32'h01000000, 32'hFF800000)};
        v[9]  = '{cop_t'(3'd5), 1'b0, 32'h00800000, 32'h01000000, 32'h00800000, 32'h00800000,
                  ex(32'h01000000, 32'h01800000, 1'b0, 32'h01000000, 32'h01800000)};
        v[10] = '{CSUB, 1'b0, 32'h0, 32'h9C000000, 32'h0, 32'h32000000,
                  ex(32'h0, 32'h80000000, 1'b1, 32'h0, 32'h6A000000)};
        v[11] = '{CMULT, 1'b0, 32'hFFFFFFFD, 32'h0, 32'h00400000, 32'h0,
                  ex(32'hFFFFFFFF, 32'h0, 1'b0, 32'hFFFFFFFF, 32'h0)};
        v[12] = '{CADD, 1'b0, 32'h7FFFFF00, 32'h0, 32'h000000FF, 32'h0,
                  ex(32'h7FFFFFFF, 32'h0, 1'b0, 32'h7FFFFFFF, 32'h0)};
        v[13] = '{CADD, 1'b0, 32'h80000000, 32'h0, 32'hFFFFFFFF, 32'h0,
                  ex(32'h80000000, 32'h0, 1'b1, 32'h7FFFFFFF, 32'h0)};
        v[14] = '{CMULT, 1'b0, 32'h64000000, 32'h0, 32'h64000000, 32'h0,
                  ex(32'h7FFFFFFF, 32'h0, 1'b1, 32'h20000000, 32'h0)};

        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_resultR", rr, 32'd0);
        chk("reset_resultI", ri, 32'd0);
        chk("reset_ovf", {31'b0, ovf}, 32'd0);
        chk("reset_in_ready", {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1;

        // Presentation cycle is cycle 0; result is visible in cycle 3.
        send(v[0].op, v[0].clr, v[0].ar, v[0].ai, v[0].br, v[0].bi, v[0].e);
        for (int j = 0; j < 3; j++) begin
            @(negedge clk);
            chk("latency_valid", {31'b0, out_valid}, (j == 2) ? 32'd1 : 32'd0);
        end
        drain();

        for (int k = 0; k < 15; k++)
            send(v[k].op, v[k].clr, v[k].ar, v[k].ai, v[k].br, v[k].bi, v[k].e);
        drain();

        fork
            begin
                for (int k = 1; k <= 6; k++)
                    send(CADD, 1'b0, 32'(k), 32'h0, 32'h0, 32'h0, ex(32'(k), 32'h0, 1'b0, 32'(k), 32'h0));
            end
            begin
                wait_out();
                @(posedge clk);
                #1 out_ready = 1'b0;
                repeat (4) begin
                    @(negedge clk);
                    chk("stall_in_ready", {31'b0, in_ready}, 32'd0);
                    chk("stall_in_ready_w", {31'b0, in_ready_w}, 32'd0);
                    @(posedge clk);
                end
                #1 out_ready = 1'b1;
            end
        join
        drain();

        out_ready = 1'b0;
        send(CMAC, 1'b1, 32'h00800000, 32'h00800000, 32'h00800000, 32'h0,
             ex(32'h00800000, 32'h00800000, 1'b0, 32'h00800000, 32'h00800000));
        send(CMAC, 1'b0, 32'h00800000, 32'h00800000, 32'h00800000, 32'h0,
             ex(32'h01000000, 32'h01000000, 1'b0, 32'h01000000, 32'h01000000));
        wait_out();
        rst = 1'b1;
        #1;
        chk("midrst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("midrst_resultR", rr, 32'd0);
        chk("midrst_resultI", ri, 32'd0);
        chk("midrst_ovf", {31'b0, ovf}, 32'd0);
        chk("midrst_in_ready", {31'b0, in_ready}, 32'd1);
        sb.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        send(CMAC, 1'b0, 32'h00800000, 32'h0, 32'h00800000, 32'h0,
             ex(32'h00800000, 32'h0, 1'b0, 32'h00800000, 32'h0));
        drain();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
